// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int unsigned BCD_W       = 4;
  localparam int unsigned ADD3_THRESH = 5;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
  function automatic bit digits_ok(input int unsigned width, input int unsigned digits);
    longint unsigned pow10;
    longint unsigned max_bin;
    if (width >= 64) return 1'b0;
    pow10   = 64'd1;
    max_bin = (64'd1 << width) - 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      if (pow10 > max_bin) return 1'b1;
      pow10 = pow10 * 64'd10;
    end
    return pow10 > max_bin;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Combinational double-dabble cell: a BCD digit of 5 or more gets +3 (mod 16).
module bcd_digit_adj
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_W'(ADD3_THRESH)) digit_o = digit_i + BCD_W'(3);
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [WIDTH-1:0]          bin_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      valid_o,
  output logic [BCD_W*DIGITS-1:0]   bcd_o
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned AW = BCD_W * DIGITS;

  if (!digits_ok(WIDTH, DIGITS)) begin : g_digits_chk
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  state_t          state, state_nxt;
  logic [WIDTH-1:0] sr;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    adj;
  logic [CW-1:0]    cnt;
  logic             busy_nxt;
  logic             valid_nxt;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (acc[g*BCD_W +: BCD_W]),
      .digit_o (adj[g*BCD_W +: BCD_W])
    );
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flags are registered from the current state, so they trail it by one cycle.
  always_comb begin
    busy_nxt  = (state == SHIFT);
    valid_nxt = (state == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sr      <= '0;
      acc     <= '0;
      cnt     <= '0;
      bcd_o   <= '0;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      busy_o  <= busy_nxt;
      valid_o <= valid_nxt;
      case (state)
        IDLE: begin
          if (start_i) begin
            sr  <= bin_i;
            acc <= '0;
            cnt <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          {acc, sr} <= {adj, sr} << 1;
          cnt       <= cnt - CW'(1);
        end
        DONE:    bcd_o <= acc;
        default: ;
      endcase
    end
  end

endmodule
